// File: rtl/nrisc_banked_regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module      : nrisc_banked_regfile_pkg
// Description : Shared defaults and bank-control decode for the banked NRISC
//               register file.
// Revision    : 1.0 - initial release
// ============================================================================
package nrisc_banked_regfile_pkg;

    localparam int NRISC_TAM         = 16;
    localparam int NRISC_NREGS       = 16;
    localparam int NRISC_NBANKS      = 4;
    localparam int NRISC_STACK_DEPTH = 4;

    typedef enum logic [1:0] {
        BANK_HOLD = 2'd0,
        BANK_TAIL = 2'd1,
        BANK_PUSH = 2'd2,
        BANK_POP  = 2'd3
    } bank_op_e;

    // Tail-chain outranks a plain enter or exit.
    function automatic bank_op_e decode_bank_op(input logic enter, input logic leave);
        if (enter && leave) return BANK_TAIL;
        if (enter)          return BANK_PUSH;
        if (leave)          return BANK_POP;
        return BANK_HOLD;
    endfunction

endpackage
`default_nettype wire

// File: rtl/nrisc_bank_stack.sv
`default_nettype none
// ============================================================================
// Module      : nrisc_bank_stack
// Description : Active-bank register with interrupt nesting stack and sticky
//               overflow/underflow flags.
// Revision    : 1.0 - initial release
// ============================================================================
module nrisc_bank_stack
    import nrisc_banked_regfile_pkg::*;
#(
    parameter int NBANKS      = NRISC_NBANKS,
    parameter int STACK_DEPTH = NRISC_STACK_DEPTH
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           enter_i,
    input  logic                           exit_i,
    input  logic [$clog2(NBANKS)-1:0]      irq_bank_i,
    input  logic                           flag_clr_i,
    output logic [$clog2(NBANKS)-1:0]      bank_o,
    output logic [$clog2(STACK_DEPTH):0]   depth_o,
    output logic                           overflow_o,
    output logic                           underflow_o
);

    localparam int c_BW = $clog2(NBANKS);
    localparam int c_DW = $clog2(STACK_DEPTH) + 1;

    logic [c_BW-1:0] stack_q [STACK_DEPTH];
    logic [c_BW-1:0] bank_q;
    logic [c_DW-1:0] depth_q;
    logic            overflow_q;
    logic            underflow_q;
    logic            overflow_d;
    logic            underflow_d;
    bank_op_e        w_op;
    logic            w_full;
    logic            w_empty;

    assign w_op    = decode_bank_op(enter_i, exit_i);
    assign w_full  = (int'(depth_q) >= STACK_DEPTH);
    assign w_empty = (depth_q == '0);

    // A set event in the same cycle as a clear leaves the flag set.
    always_comb begin
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (flag_clr_i) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
        if (w_op == BANK_PUSH && w_full)  overflow_d  = 1'b1;
        if (w_op == BANK_POP  && w_empty) underflow_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int s = 0; s < STACK_DEPTH; s++) stack_q[s] <= '0;
            bank_q      <= '0;
            depth_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            case (w_op)
                BANK_TAIL: bank_q <= irq_bank_i;
                BANK_PUSH: begin
                    if (!w_full) begin
                        for (int s = 0; s < STACK_DEPTH; s++)
                            if (int'(depth_q) == s) stack_q[s] <= bank_q;
                        bank_q  <= irq_bank_i;
                        depth_q <= depth_q + c_DW'(1);
                    end
                end
                BANK_POP: begin
                    if (!w_empty) begin
                        for (int s = 0; s < STACK_DEPTH; s++)
                            if (int'(depth_q) == s + 1) bank_q <= stack_q[s];
                        depth_q <= depth_q - c_DW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bank_o      = bank_q;
    assign depth_o     = depth_q;
    assign overflow_o  = overflow_q;
    assign underflow_o = underflow_q;

endmodule
`default_nettype wire

// File: rtl/nrisc_banked_regfile.sv
`default_nettype none
// ============================================================================
// Module      : nrisc_banked_regfile
// Description : NRISC register file with global window, banked upper window,
//               nested bank switching and same-cycle write bypass.
// Revision    : 1.0 - initial release
// ============================================================================
module nrisc_banked_regfile
    import nrisc_banked_regfile_pkg::*;
#(
    parameter int TAM         = NRISC_TAM,
    parameter int NREGS       = NRISC_NREGS,
    parameter int GLOBAL_HI   = 7,
    parameter int NBANKS      = NRISC_NBANKS,
    parameter int STACK_DEPTH = NRISC_STACK_DEPTH,
    parameter int BYPASS      = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    output logic [TAM-1:0]                 REG_A,
    output logic [TAM-1:0]                 REG_B,
    input  logic [$clog2(NREGS)-1:0]       REG_RF1,
    input  logic [$clog2(NREGS)-1:0]       REG_RF2,
    input  logic [$clog2(NREGS)-1:0]       REG_RFD,
    input  logic [TAM-1:0]                 REG_D,
    input  logic                           REG_Write,
    input  logic [TAM-1:0]                 REG_R1,
    input  logic                           REG_Irq_enter,
    input  logic [$clog2(NBANKS)-1:0]      REG_Irq_bank,
    input  logic                           REG_Irq_exit,
    input  logic                           REG_Flag_clr,
    output logic [$clog2(NBANKS)-1:0]      REG_Bank,
    output logic [$clog2(STACK_DEPTH):0]   REG_Depth,
    output logic                           REG_Overflow,
    output logic                           REG_Underflow
);

    localparam int c_AW      = $clog2(NREGS);
    localparam int c_NGLOB   = GLOBAL_HI - 1;
    localparam int c_NBANKED = NREGS - GLOBAL_HI - 1;

    logic [TAM-1:0] glob_q [c_NGLOB];
    logic [TAM-1:0] bank_mem_q [NBANKS][c_NBANKED];

    nrisc_bank_stack #(
        .NBANKS      (NBANKS),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_bank_stack (
        .clk         (clk),
        .rst         (rst),
        .enter_i     (REG_Irq_enter),
        .exit_i      (REG_Irq_exit),
        .irq_bank_i  (REG_Irq_bank),
        .flag_clr_i  (REG_Flag_clr),
        .bank_o      (REG_Bank),
        .depth_o     (REG_Depth),
        .overflow_o  (REG_Overflow),
        .underflow_o (REG_Underflow)
    );

    function automatic logic [TAM-1:0] read_reg(input logic [c_AW-1:0] addr);
        logic [TAM-1:0] val;
        val = '0;
        if (addr == c_AW'(1)) begin
            val = REG_R1;
        end else if (int'(addr) >= 2) begin
            for (int g = 0; g < c_NGLOB; g++)
                if (int'(addr) == g + 2) val = glob_q[g];
            for (int b = 0; b < NBANKS; b++)
                for (int k = 0; k < c_NBANKED; k++)
                    if (int'(REG_Bank) == b && int'(addr) == k + GLOBAL_HI + 1)
                        val = bank_mem_q[b][k];
            if (BYPASS != 0 && REG_Write && REG_RFD == addr) val = REG_D;
        end
        return val;
    endfunction

    always_comb begin
        REG_A = read_reg(REG_RF1);
        REG_B = read_reg(REG_RF2);
    end

    // Banked writes use REG_Bank as seen before this edge, so a write issued
    // alongside enter/exit lands in the outgoing bank.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int g = 0; g < c_NGLOB; g++) glob_q[g] <= '0;
            for (int b = 0; b < NBANKS; b++)
                for (int k = 0; k < c_NBANKED; k++) bank_mem_q[b][k] <= '0;
        end else if (REG_Write) begin
            for (int g = 0; g < c_NGLOB; g++)
                if (int'(REG_RFD) == g + 2) glob_q[g] <= REG_D;
            for (int b = 0; b < NBANKS; b++)
                for (int k = 0; k < c_NBANKED; k++)
                    if (int'(REG_Bank) == b && int'(REG_RFD) == k + GLOBAL_HI + 1)
                        bank_mem_q[b][k] <= REG_D;
        end
    end

endmodule
`default_nettype wire
